// File: rtl/pulpino_mailbox.sv
// Byte mailbox between a host register block and the PULPino core.
// Latency: host RX byte reaches rx_valid 1 cycle after the toggle edge is sampled; TX byte reaches O_pulpino_data on the accepting edge.
// Backpressure: RX FIFO full drops host bytes and sets a sticky overflow flag; TX holds tx_ready low until the host acks.
//
// Ports:
//    crypto_clk, reset_n_i          clock, asynchronous active-low reset
//    I_ext_data / I_ext_flags       host byte and host toggles ([0] RX, [1] TX-ack, [2] overflow clear)
//    rx_data / rx_valid / rx_ready  FIFO head towards the core
//    tx_data / tx_valid / tx_ready  core byte towards the host
//    O_pulpino_data / O_pulpino_flags  host-visible byte and status
//
// Optional: define PULPINO_MBX_SYNC_EN to pass I_ext_flags[2:0] through a
// 2-flop synchronizer, adding 2 cycles to RX and ack latency.
module pulpino_mailbox #(
   parameter int pRX_DEPTH = 4
) (
   input  logic       crypto_clk,
   input  logic       reset_n_i,
   input  logic [7:0] I_ext_data,
   input  logic [7:0] I_ext_flags,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] O_pulpino_data,
   output logic [7:0] O_pulpino_flags
);

   localparam int AW = $clog2(pRX_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} tx_state_t;

   // Host flags as seen by the edge detectors.
   logic [2:0] host_flags;

`ifdef PULPINO_MBX_SYNC_EN
   logic [2:0] sync_1;
   logic [2:0] sync_2;

   always_ff @(posedge crypto_clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync_1 <= '0;
         sync_2 <= '0;
      end else begin
         sync_1 <= I_ext_flags[2:0];
         sync_2 <= sync_1;
      end
   end

   assign host_flags = sync_2;
`else
   assign host_flags = I_ext_flags[2:0];
`endif

   // Bits [7:3] of the host flags carry no meaning here.
   logic unused_flags;
   assign unused_flags = ^I_ext_flags[7:3];

   // ------------------------------------------------------------------
   // Edge detection on host toggles
   // ------------------------------------------------------------------
   logic rx_prev;
   logic ack_prev;
   logic rx_edge;
   logic ack_edge;

   assign rx_edge  = host_flags[0] ^ rx_prev;
   assign ack_edge = host_flags[1] ^ ack_prev;

   // ------------------------------------------------------------------
   // RX FIFO
   // ------------------------------------------------------------------
   logic [7:0]    mem [pRX_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic [4:0]    count_ext;
   logic          full;
   logic          push;
   logic          pop;
   logic          ovf_set;
   logic          rx_full_flag;
   logic          ovf_flag;
   logic [2:0]    rx_count_flag;

   assign full = (count == CW'(pRX_DEPTH));
   assign pop  = rx_valid & rx_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push    = rx_edge & (~full | pop);
   assign ovf_set = rx_edge & full & ~pop;

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   assign count_ext = 5'(count_nxt);

   // Storage needs no reset: rx_data is only meaningful while rx_valid is high.
   always_ff @(posedge crypto_clk) begin
      if (push) begin
         mem[wr_ptr] <= I_ext_data;
      end
   end

   assign rx_data = mem[rd_ptr];

   always_ff @(posedge crypto_clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rx_prev       <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         rx_valid      <= 1'b0;
         rx_full_flag  <= 1'b0;
         rx_count_flag <= 3'd0;
         ovf_flag      <= 1'b0;
      end else begin
         rx_prev <= host_flags[0];
         // Pointers wrap naturally since the depth is a power of two.
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count         <= count_nxt;
         rx_valid      <= (count_nxt != '0);
         rx_full_flag  <= (count_nxt == CW'(pRX_DEPTH));
         rx_count_flag <= (count_ext > 5'd7) ? 3'd7 : count_ext[2:0];
         // Set wins over a simultaneous clear so no overflow is ever lost.
         if (ovf_set) begin
            ovf_flag <= 1'b1;
         end else if (host_flags[2]) begin
            ovf_flag <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // TX FSM
   // ------------------------------------------------------------------
   tx_state_t tx_state;
   logic      tx_toggle;
   logic      tx_busy;

   always_ff @(posedge crypto_clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         tx_state       <= IDLE;
         tx_ready       <= 1'b1;
         tx_toggle      <= 1'b0;
         tx_busy        <= 1'b0;
         O_pulpino_data <= 8'h00;
         ack_prev       <= 1'b0;
      end else begin
         // The copy tracks the host toggle in every state; in IDLE an ack edge
         // has no other effect.
         ack_prev <= host_flags[1];
         case (tx_state)
            IDLE: begin
               if (tx_valid) begin
                  O_pulpino_data <= tx_data;
                  tx_toggle      <= ~tx_toggle;
                  tx_busy        <= 1'b1;
                  tx_ready       <= 1'b0;
                  tx_state       <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (ack_edge) begin
                  tx_busy  <= 1'b0;
                  tx_ready <= 1'b1;
                  tx_state <= IDLE;
               end
            end
            default: begin
               tx_state <= IDLE;
               tx_ready <= 1'b1;
               tx_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign O_pulpino_flags = {1'b0, rx_count_flag, tx_busy, ovf_flag, rx_full_flag, tx_toggle};

endmodule

// File: doc/pulpino_mailbox.md
PULPINO_MAILBOX -- requirements
Module: pulpino_mailbox

Interface
REQ-001 Parameter: pRX_DEPTH, default 4, RX FIFO depth in bytes, power of two, 2 to 16.
REQ-002 Port: crypto_clk  input  1  sole clock; all state on its rising edge.
REQ-003 Port: reset_n_i  input  1  asynchronous, active-low reset.
REQ-004 Port: I_ext_data  input  8  host-to-core byte from the host register block.
REQ-005 Port: I_ext_flags  input  8  host flags: [0] RX toggle (byte posted), [1] TX-ack toggle, [2] overflow clear (level), [7:3] ignored.
REQ-006 Port: rx_data  output  8  FIFO head byte to core.
REQ-007 Port: rx_valid  output  1  FIFO non-empty.
REQ-008 Port: rx_ready  input  1  core pops the head when rx_valid && rx_ready.
REQ-009 Port: tx_data  input  8  core-to-host byte.
REQ-010 Port: tx_valid  input  1  core offers tx_data.
REQ-011 Port: tx_ready  output  1  block accepts tx_data this cycle.
REQ-012 Port: O_pulpino_data  output  8  byte presented to the host register block.
REQ-013 Port: O_pulpino_flags  output  8  status: [0] TX toggle, [1] RX full, [2] overflow sticky, [3] TX busy, [6:4] RX count (saturating at 7), [7] 0.

Function
REQ-014 The block SHALL keep an internal copy of each sampled toggle (rx_prev, ack_prev); an edge is sampled toggle != copy, and the copy SHALL be updated on the same edge.
REQ-015 An RX edge SHALL push I_ext_data (sampled on that edge) into the FIFO if not full, or if full and a pop occurs in the same cycle.
REQ-016 An RX edge while full without a simultaneous pop SHALL drop the byte and set flags[2].
REQ-017 flags[2] SHALL clear only on reset or while I_ext_flags[2] is sampled high; a clear and a set in the same cycle SHALL leave it set.
REQ-018 The FIFO SHALL be registered, with no fall-through: rx_valid rises on the clock after the push into an empty FIFO.
REQ-019 Pop and push in the same cycle SHALL leave the count unchanged and preserve order.
REQ-020 Read and write pointers SHALL wrap modulo pRX_DEPTH.
REQ-021 flags[1] SHALL equal (count == pRX_DEPTH), and flags[6:4] SHALL equal min(count, 7); both SHALL be registered and updated with the count.
REQ-022 The TX FSM SHALL have two states, IDLE and WAIT_ACK, and tx_ready SHALL be 1 exactly in IDLE.
REQ-023 In IDLE, tx_valid SHALL load tx_data into O_pulpino_data, invert flags[0], set flags[3] and enter WAIT_ACK on the same edge.
REQ-024 In WAIT_ACK, an ack edge SHALL clear flags[3] and return to IDLE; tx_ready SHALL be high on the following cycle.
REQ-025 An ack edge in IDLE SHALL update ack_prev only, with no other effect.
REQ-026 O_pulpino_data SHALL hold its value until the next accepted TX byte.
REQ-027 RX and TX paths SHALL be independent; simultaneous events on both SHALL each be processed in the same cycle.

Reset
REQ-028 Reset assertion SHALL immediately set the following to zero:
  - FIFO pointers and count
  - rx_valid
  - rx_prev, ack_prev
  - O_pulpino_data, O_pulpino_flags
  - FSM state to IDLE
  - tx_ready to 1 (IDLE).
REQ-029 Reset mid-operation SHALL discard FIFO contents and any unacknowledged TX byte.
REQ-030 rx_data SHALL be don't-care while rx_valid is 0.
REQ-031 After release, the first edge SHALL be detected relative to zeroed copies, matching the host flag reset value of 0.

Configuration
REQ-032 With PULPINO_MBX_SYNC_EN defined, I_ext_flags[2:0] SHALL pass through a 2-flop synchronizer (reset to 0) before edge detection, adding exactly 2 cycles to RX and ack latency.
REQ-033 Without PULPINO_MBX_SYNC_EN, I_ext_flags SHALL be sampled directly.
REQ-034 I_ext_data SHALL never be synchronized; the host writes data before toggling.

Verification
REQ-035 Empty FIFO, I_ext_data=0xA5, then I_ext_flags[0] 0->1 -> rx_valid=1, rx_data=0xA5 one cycle after the edge cycle (three with SYNC_EN); flags[6:4]=1.
REQ-036 Four toggles with 0x01..0x04 and rx_ready=0, then a fifth with 0x05 -> flags[1]=1, flags[2]=1; pops return 0x01..0x04 and rx_valid drops.
REQ-037 FIFO full, rx_ready=1 on the same cycle as an RX edge with 0x55 -> no overflow, count stays 4, 0x55 is popped last.
REQ-038 tx_valid with tx_data=0x3C -> O_pulpino_data=0x3C, flags[0] inverts, flags[3]=1, tx_ready=0; a second tx_valid is ignored.
REQ-039 Then I_ext_flags[1] toggles -> flags[3]=0 and tx_ready=1 the next cycle; an ack toggle in IDLE causes no change.
REQ-040 reset_n_i pulsed low with 3 bytes queued and TX in WAIT_ACK -> all outputs 0 asynchronously, tx_ready=1, and the FIFO is empty after release.
